// File: rtl/regfile_scoreboard_if.sv
// Issue / writeback / status bundle between a dual-issue pipeline and its
// register scoreboard. The pipeline side is the master, the scoreboard the slave.
interface regfile_scoreboard_if #(
  parameter int NR_REG = 32
);
  localparam int RW = (NR_REG > 1) ? $clog2(NR_REG) : 1;

  logic              flush;
  logic              iss_valid1;
  logic              iss_valid2;
  logic              iss_wen1;
  logic              iss_wen2;
  logic [RW-1:0]     iss_rd1;
  logic [RW-1:0]     iss_rd2;
  logic [RW-1:0]     iss_rs1;
  logic [RW-1:0]     iss_rs2;
  logic [RW-1:0]     iss_rs3;
  logic [RW-1:0]     iss_rs4;
  logic              wb_valid1;
  logic              wb_valid2;
  logic [RW-1:0]     wb_rd1;
  logic [RW-1:0]     wb_rd2;
  logic              iss_ok1;
  logic              iss_ok2;
  logic [NR_REG-1:0] busy;
  logic              sb_err;

  modport master (
    output flush, iss_valid1, iss_valid2, iss_wen1, iss_wen2,
    output iss_rd1, iss_rd2, iss_rs1, iss_rs2, iss_rs3, iss_rs4,
    output wb_valid1, wb_valid2, wb_rd1, wb_rd2,
    input  iss_ok1, iss_ok2, busy, sb_err
  );

  modport slave (
    input  flush, iss_valid1, iss_valid2, iss_wen1, iss_wen2,
    input  iss_rd1, iss_rd2, iss_rs1, iss_rs2, iss_rs3, iss_rs4,
    input  wb_valid1, wb_valid2, wb_rd1, wb_rd2,
    output iss_ok1, iss_ok2, busy, sb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register scoreboard for a dual-issue in-order pipeline. Each architectural
// register carries a small counter of writes that have issued but not yet
// written back. Sources with a pending write stall, a destination whose counter
// is full stalls, and slot 2 never issues ahead of slot 1. Register 0 is
// hard-wired and never tracked.
module regfile_scoreboard #(
  parameter int NR_REG = 32,
  parameter int CNT_W  = 2
) (
  input logic                 clock,
  input logic                 reset,
  regfile_scoreboard_if.slave sb
);
  localparam int RW = (NR_REG > 1) ? $clog2(NR_REG) : 1;
  localparam int EW = CNT_W + 2;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [EW-1:0]    ext_t;

  localparam cnt_t          CNT_ZERO = {CNT_W{1'b0}};
  localparam cnt_t          CMAX     = {CNT_W{1'b1}};
  localparam ext_t          CMAX_E   = {2'b00, CMAX};
  localparam ext_t          EXT_ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] IDX_ZERO = {RW{1'b0}};

  cnt_t              cnt_q [NR_REG];
  cnt_t              cnt_d [NR_REG];
  logic [NR_REG-1:0] busy_q;
  logic [NR_REG-1:0] busy_d;
  logic              sb_err_q;
  logic              sb_err_d;

  logic              ok1_s;
  logic              ok2_s;
  logic              fire1_s;
  logic              fire2_s;
  logic              rd1_sat_s;
  logic              rd2_sat_s;
  logic              raw_s;

  // A nonzero source register with any write still in flight is a hazard.
  function automatic logic src_hazard(input logic [RW-1:0] idx, input cnt_t cnt);
    return (idx != IDX_ZERO) && (cnt != CNT_ZERO);
  endfunction

  // Issue permission for both slots, from registered counters only (no wb bypass).
  always_comb begin
    rd1_sat_s = 1'b0;
    rd2_sat_s = 1'b0;
    raw_s     = 1'b0;

    if (sb.iss_wen1 && (sb.iss_rd1 != IDX_ZERO)) begin
      rd1_sat_s = (cnt_q[sb.iss_rd1] == CMAX);
    end else begin
      rd1_sat_s = 1'b0;
    end

    // When both slots target the same register, slot 2 sees slot 1's increment.
    if (sb.iss_wen2 && (sb.iss_rd2 != IDX_ZERO)) begin
      if (sb.iss_wen1 && (sb.iss_rd1 == sb.iss_rd2)) begin
        rd2_sat_s = ({2'b00, cnt_q[sb.iss_rd2]} + EXT_ONE) >= CMAX_E;
      end else begin
        rd2_sat_s = (cnt_q[sb.iss_rd2] == CMAX);
      end
    end else begin
      rd2_sat_s = 1'b0;
    end

    if (sb.iss_wen1) begin
      raw_s = ((sb.iss_rs3 != IDX_ZERO) && (sb.iss_rs3 == sb.iss_rd1)) ||
              ((sb.iss_rs4 != IDX_ZERO) && (sb.iss_rs4 == sb.iss_rd1));
    end else begin
      raw_s = 1'b0;
    end

    ok1_s = !sb.flush &&
            !src_hazard(sb.iss_rs1, cnt_q[sb.iss_rs1]) &&
            !src_hazard(sb.iss_rs2, cnt_q[sb.iss_rs2]) &&
            !rd1_sat_s;

    ok2_s = ok1_s && sb.iss_valid1 && !sb.flush &&
            !src_hazard(sb.iss_rs3, cnt_q[sb.iss_rs3]) &&
            !src_hazard(sb.iss_rs4, cnt_q[sb.iss_rs4]) &&
            !raw_s && !rd2_sat_s;

    fire1_s = sb.iss_valid1 && ok1_s;
    fire2_s = sb.iss_valid2 && ok2_s;
  end

  // Next counter values: issues add, writebacks subtract, all in one step;
  // an underflow clamps to zero and latches the sticky error.
  always_comb begin
    ext_t inc_s;
    ext_t dec_s;
    ext_t sum_s;
    inc_s    = {EW{1'b0}};
    dec_s    = {EW{1'b0}};
    sum_s    = {EW{1'b0}};
    sb_err_d = sb_err_q;
    busy_d   = {NR_REG{1'b0}};
    cnt_d[0] = CNT_ZERO;
    for (int r = 1; r < NR_REG; r++) begin
      inc_s = ext_t'(fire1_s && sb.iss_wen1 && (sb.iss_rd1 == RW'(r))) +
              ext_t'(fire2_s && sb.iss_wen2 && (sb.iss_rd2 == RW'(r)));
      dec_s = ext_t'(sb.wb_valid1 && (sb.wb_rd1 == RW'(r))) +
              ext_t'(sb.wb_valid2 && (sb.wb_rd2 == RW'(r)));
      sum_s = {2'b00, cnt_q[r]} + inc_s;
      if (sb.flush) begin
        cnt_d[r] = CNT_ZERO;
      end else if (dec_s > sum_s) begin
        cnt_d[r] = CNT_ZERO;
        sb_err_d = 1'b1;
      end else begin
        cnt_d[r] = cnt_t'(sum_s - dec_s);
      end
      busy_d[r] = (cnt_d[r] != CNT_ZERO);
    end
  end

  // State registers; reset dominates flush, issue and writeback.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NR_REG; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      busy_q   <= {NR_REG{1'b0}};
      sb_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NR_REG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb.iss_ok1 = ok1_s;
  assign sb.iss_ok2 = ok2_s;
  assign sb.busy    = busy_q;
  assign sb.sb_err  = sb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed cycle table for the named scenarios,
// then random traffic checked against a counting model held in plain ints.
module tb_regfile_scoreboard;
  localparam int NR   = 32;
  localparam int CW   = 2;
  localparam int CMAX = 3;
  localparam int NVEC = 29;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  regfile_scoreboard_if #(.NR_REG(NR)) sb_if();
  regfile_scoreboard #(.NR_REG(NR), .CNT_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .sb   (sb_if)
  );

  typedef struct {
    bit rstn; bit fl;
    bit v1; bit w1; int rd1; int rs1; int rs2;
    bit v2; bit w2; int rd2; int rs3; int rs4;
    bit b1; int br1; bit b2; int br2;
  } in_t;

  typedef struct {
    bit rstn; bit fl;
    bit v1; bit w1; int rd1; int rs1; int rs2;
    bit v2; bit w2; int rd2; int rs3; int rs4;
    bit b1; int br1; bit b2; int br2;
    bit ok1; bit ok2; int creg; bit busy; bit err;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cnt_m [NR];
  bit   err_m = 1'b0;
  logic got_ok1;
  logic got_ok2;
  vec_t tbl [NVEC];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit hz(input int r);
    return (r != 0) && (cnt_m[r] > 0);
  endfunction

  function automatic in_t in_of(input vec_t v);
    in_t x;
    x.rstn = v.rstn; x.fl = v.fl;
    x.v1 = v.v1; x.w1 = v.w1; x.rd1 = v.rd1; x.rs1 = v.rs1; x.rs2 = v.rs2;
    x.v2 = v.v2; x.w2 = v.w2; x.rd2 = v.rd2; x.rs3 = v.rs3; x.rs4 = v.rs4;
    x.b1 = v.b1; x.br1 = v.br1; x.b2 = v.b2; x.br2 = v.br2;
    return x;
  endfunction

  // One clock: drive at negedge, check issue permission, then check state after posedge.
  task automatic step(input in_t x, input string tag);
    bit e1;
    bit e2;
    int pend2;
    int n;
    logic [NR-1:0] eb;
    @(negedge clock);
    reset               = x.rstn;
    sb_if.flush         = x.fl;
    sb_if.iss_valid1    = x.v1;
    sb_if.iss_wen1      = x.w1;
    sb_if.iss_rd1       = 5'(x.rd1);
    sb_if.iss_rs1       = 5'(x.rs1);
    sb_if.iss_rs2       = 5'(x.rs2);
    sb_if.iss_valid2    = x.v2;
    sb_if.iss_wen2      = x.w2;
    sb_if.iss_rd2       = 5'(x.rd2);
    sb_if.iss_rs3       = 5'(x.rs3);
    sb_if.iss_rs4       = 5'(x.rs4);
    sb_if.wb_valid1     = x.b1;
    sb_if.wb_rd1        = 5'(x.br1);
    sb_if.wb_valid2     = x.b2;
    sb_if.wb_rd2        = 5'(x.br2);
    #1;
    e1 = !x.fl && !hz(x.rs1) && !hz(x.rs2) &&
         !(x.w1 && x.rd1 != 0 && cnt_m[x.rd1] == CMAX);
    pend2 = cnt_m[x.rd2] + ((x.w1 && x.rd1 == x.rd2) ? 1 : 0);
    e2 = e1 && x.v1 && !x.fl && !hz(x.rs3) && !hz(x.rs4) &&
         !(x.w1 && ((x.rs3 != 0 && x.rs3 == x.rd1) || (x.rs4 != 0 && x.rs4 == x.rd1))) &&
         !(x.w2 && x.rd2 != 0 && pend2 + 1 > CMAX);
    got_ok1 = sb_if.iss_ok1;
    got_ok2 = sb_if.iss_ok2;
    check_eq({tag, " model_ok1"}, 64'(got_ok1), 64'(e1));
    check_eq({tag, " model_ok2"}, 64'(got_ok2), 64'(e2));
    @(posedge clock);
    #1;
    if (!x.rstn) begin
      for (int r = 0; r < NR; r++) cnt_m[r] = 0;
      err_m = 1'b0;
    end else if (x.fl) begin
      for (int r = 0; r < NR; r++) cnt_m[r] = 0;
    end else begin
      for (int r = 1; r < NR; r++) begin
        n = cnt_m[r]
          + ((x.v1 && e1 && x.w1 && x.rd1 == r) ? 1 : 0)
          + ((x.v2 && e2 && x.w2 && x.rd2 == r) ? 1 : 0)
          - ((x.b1 && x.br1 == r) ? 1 : 0)
          - ((x.b2 && x.br2 == r) ? 1 : 0);
        if (n < 0) begin
          n = 0;
          err_m = 1'b1;
        end
        cnt_m[r] = n;
      end
    end
    eb = '0;
    for (int r = 0; r < NR; r++) eb[r] = (cnt_m[r] != 0);
    check_eq({tag, " model_busy"}, 64'(sb_if.busy), 64'(eb));
    check_eq({tag, " model_err"}, 64'(sb_if.sb_err), 64'(err_m));
  endtask

  initial begin
    in_t x;
    int  r;
    // rstn fl | v1 w1 rd1 rs1 rs2 | v2 w2 rd2 rs3 rs4 | b1 br1 b2 br2 | ok1 ok2 creg busy err
    tbl[0]  = '{0,0, 0,0,0,0,0,   0,0,0,0,0,   0,0,0,0,   1,0,5,0,0};
    tbl[1]  = '{1,0, 1,1,5,0,0,   0,0,0,0,0,   0,0,0,0,   1,1,5,1,0};
    tbl[2]  = '{1,0, 1,0,0,5,0,   0,0,0,0,0,   0,0,0,0,   0,0,5,1,0};
    tbl[3]  = '{1,0, 1,0,0,5,0,   0,0,0,0,0,   1,5,0,0,   0,0,5,0,0};
    tbl[4]  = '{1,0, 1,0,0,5,0,   0,0,0,0,0,   0,0,0,0,   1,1,5,0,0};
    tbl[5]  = '{1,0, 1,1,7,0,0,   1,0,0,7,0,   0,0,0,0,   1,0,7,1,0};
    tbl[6]  = '{1,0, 0,0,0,0,0,   0,0,0,0,0,   1,7,0,0,   1,0,7,0,0};
    tbl[7]  = '{1,0, 1,1,0,0,0,   1,0,0,7,0,   0,0,0,0,   1,1,0,0,0};
    tbl[8]  = '{1,0, 1,1,9,0,0,   0,0,0,0,0,   0,0,0,0,   1,1,9,1,0};
    tbl[9]  = '{1,0, 1,1,9,0,0,   0,0,0,0,0,   0,0,0,0,   1,1,9,1,0};
    tbl[10] = '{1,0, 1,1,9,0,0,   0,0,0,0,0,   0,0,0,0,   1,1,9,1,0};
    tbl[11] = '{1,0, 1,1,9,0,0,   0,0,0,0,0,   0,0,0,0,   0,0,9,1,0};
    tbl[12] = '{1,0, 1,1,9,0,0,   0,0,0,0,0,   1,9,0,0,   0,0,9,1,0};
    tbl[13] = '{1,0, 1,1,9,0,0,   0,0,0,0,0,   0,0,0,0,   1,1,9,1,0};
    tbl[14] = '{1,0, 0,0,0,0,0,   0,0,0,0,0,   1,9,1,9,   1,0,9,1,0};
    tbl[15] = '{1,0, 0,0,0,0,0,   0,0,0,0,0,   1,9,0,0,   1,0,9,0,0};
    tbl[16] = '{1,0, 1,1,4,0,0,   0,0,0,0,0,   0,0,0,0,   1,1,4,1,0};
    tbl[17] = '{1,0, 1,1,4,0,0,   0,0,0,0,0,   1,4,0,0,   1,1,4,1,0};
    tbl[18] = '{1,0, 0,0,0,0,0,   0,0,0,0,0,   1,4,0,0,   1,0,4,0,0};
    tbl[19] = '{1,0, 0,0,0,0,0,   0,0,0,0,0,   0,0,1,12,  1,0,12,0,1};
    tbl[20] = '{1,0, 1,1,3,0,0,   0,0,0,0,0,   0,0,0,0,   1,1,3,1,1};
    tbl[21] = '{1,0, 1,1,3,0,0,   0,0,0,0,0,   0,0,0,0,   1,1,3,1,1};
    tbl[22] = '{1,1, 1,1,3,0,0,   0,0,0,0,0,   1,5,0,0,   0,0,3,0,1};
    tbl[23] = '{1,0, 0,0,0,0,0,   0,0,0,0,0,   0,0,0,0,   1,0,3,0,1};
    tbl[24] = '{0,0, 0,0,0,0,0,   0,0,0,0,0,   0,0,0,0,   1,0,3,0,0};
    tbl[25] = '{1,0, 1,1,10,0,0,  1,1,10,0,0,  0,0,0,0,   1,1,10,1,0};
    tbl[26] = '{1,0, 1,1,10,0,0,  1,1,10,0,0,  0,0,0,0,   1,0,10,1,0};
    tbl[27] = '{1,0, 1,1,11,0,0,  1,1,10,0,0,  0,0,0,0,   1,0,11,1,0};
    tbl[28] = '{1,0, 1,1,13,0,0,  1,0,0,0,13,  0,0,0,0,   1,0,13,1,0};

    for (int i = 0; i < NR; i++) cnt_m[i] = 0;
    sb_if.flush = 1'b0;
    sb_if.iss_valid1 = 1'b0; sb_if.iss_wen1 = 1'b0;
    sb_if.iss_valid2 = 1'b0; sb_if.iss_wen2 = 1'b0;
    sb_if.iss_rd1 = '0; sb_if.iss_rd2 = '0;
    sb_if.iss_rs1 = '0; sb_if.iss_rs2 = '0; sb_if.iss_rs3 = '0; sb_if.iss_rs4 = '0;
    sb_if.wb_valid1 = 1'b0; sb_if.wb_valid2 = 1'b0;
    sb_if.wb_rd1 = '0; sb_if.wb_rd2 = '0;
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // Directed scenarios, one table row per clock.
    for (int i = 0; i < NVEC; i++) begin
      step(in_of(tbl[i]), $sformatf("vec%0d", i));
      check_eq($sformatf("vec%0d ok1", i), 64'(got_ok1), 64'(tbl[i].ok1));
      check_eq($sformatf("vec%0d ok2", i), 64'(got_ok2), 64'(tbl[i].ok2));
      check_eq($sformatf("vec%0d busy[%0d]", i, tbl[i].creg),
               64'(sb_if.busy[tbl[i].creg]), 64'(tbl[i].busy));
      check_eq($sformatf("vec%0d sb_err", i), 64'(sb_if.sb_err), 64'(tbl[i].err));
    end

    // Random traffic on a small register window so hazards are frequent.
    x = '{default: 0};
    step(x, "rnd_reset");
    for (int c = 0; c < 600; c++) begin
      x.rstn = ($urandom_range(0, 99) != 0);
      x.fl   = ($urandom_range(0, 29) == 0);
      x.v1   = ($urandom_range(0, 3) != 0);
      x.w1   = $urandom_range(0, 1);
      x.rd1  = $urandom_range(0, 7);
      x.rs1  = $urandom_range(0, 7);
      x.rs2  = $urandom_range(0, 7);
      x.v2   = ($urandom_range(0, 3) != 0);
      x.w2   = $urandom_range(0, 1);
      x.rd2  = $urandom_range(0, 7);
      x.rs3  = $urandom_range(0, 7);
      x.rs4  = $urandom_range(0, 7);
      r = $urandom_range(1, 7);
      x.b1 = (cnt_m[r] > 0) && ($urandom_range(0, 1) == 1);
      x.br1 = r;
      if (!x.b1 && $urandom_range(0, 49) == 0) begin
        x.b1  = 1'b1;
        x.br1 = $urandom_range(0, 7);
      end
      r = $urandom_range(1, 7);
      x.b2 = (cnt_m[r] > 0) && ($urandom_range(0, 2) == 0);
      x.br2 = r;
      if (!x.b2 && $urandom_range(0, 49) == 0) begin
        x.b2  = 1'b1;
        x.br2 = $urandom_range(0, 7);
      end
      step(x, $sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
